// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared Mini-MIPS constants for the multiply/divide unit
// Contents: op encodings, MDU FSM state type, iteration count.
package mips_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam int MDU_ITERS = 32;
  localparam logic [4:0] MDU_CNT_LAST = 5'(MDU_ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - operand/HI-LO bus between pipeline and multiply/divide unit
// master: pipeline side (drives start/op/operands/MTHI-MTLO write)
// slave:  mult_div_unit (drives busy/done/div_zero/hi/lo)
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hilo_we;
  logic        hilo_sel;
  logic [31:0] hilo_wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_data, rt_data, hilo_we, hilo_sel, hilo_wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, hilo_we, hilo_sel, hilo_wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - 32-bit restoring divider datapath, one quotient bit per step
// Ports: clk, rst (async active-low), load (latch operands), step (one iteration),
//        dividend/divisor (magnitudes), quotient/remainder (valid after 32 steps).
module mdu_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] divisor_q;
  logic [32:0] shifted;
  logic [33:0] diff;

  // Quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder while the new quotient bit enters at the LSB.
  assign shifted = {remainder, quotient[31]};
  assign diff    = {1'b0, shifted} - {2'b00, divisor_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quotient  <= '0;
      remainder <= '0;
      divisor_q <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      divisor_q <= divisor;
    end else if (step) begin
      // Borrow means the trial subtraction failed: restore (keep shifted value).
      remainder <= diff[33] ? shifted[31:0] : diff[31:0];
      quotient  <= {quotient[30:0], ~diff[33]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
// Ports: clk, rst (async active-low), bus (mult_div_unit_if.slave):
//   start/op/rs_data/rt_data launch, hilo_we/hilo_sel/hilo_wdata MTHI/MTLO,
//   busy/done/div_zero status, hi/lo architectural registers.
// Build option: MDU_DIV_EN builds the divider; otherwise DIV/DIVU are no-ops.
module mult_div_unit
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mult_div_unit_if.slave  bus
);

  mdu_state_t  state;
  logic [4:0]  cnt;
  logic        op_div_q;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] a_mag;
  logic [63:0] acc;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        is_div;
  logic        is_signed;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [32:0] mul_sum;
  logic [63:0] prod_fix;

  assign is_div    = bus.op[1];
  assign is_signed = ~bus.op[0];
  assign rs_mag    = (is_signed && bus.rs_data[31]) ? -bus.rs_data : bus.rs_data;
  assign rt_mag    = (is_signed && bus.rt_data[31]) ? -bus.rt_data : bus.rt_data;

  // acc = {partial product, remaining multiplier bits}; add then shift right.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
  assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;

`ifdef MDU_DIV_EN
  logic        dz_q;
  logic        div_zero_q;
  logic        div_load;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign div_load = (state == IDLE) && bus.start && is_div && (bus.rt_data != 32'd0);
  assign quo_fix  = (sign_a ^ sign_b) ? -quo : quo;
  assign rem_fix  = sign_a ? -rem : rem;

  mdu_divider u_divider (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (state == DIV),
    .dividend  (rs_mag),
    .divisor   (rt_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  assign bus.div_zero = div_zero_q;
`else
  assign bus.div_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_div_q <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      a_mag    <= '0;
      acc      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MDU_DIV_EN
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MDU_DIV_EN
      div_zero_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.hilo_we) begin
            if (bus.hilo_sel) hi_q <= bus.hilo_wdata;
            else              lo_q <= bus.hilo_wdata;
          end
          if (bus.start) begin
            op_div_q <= is_div;
            sign_a   <= is_signed & bus.rs_data[31];
            sign_b   <= is_signed & bus.rt_data[31];
            a_mag    <= rs_mag;
            acc      <= {32'd0, rt_mag};
            cnt      <= '0;
            busy_q   <= 1'b1;
            if (!is_div) begin
              state <= MUL;
            end
`ifdef MDU_DIV_EN
            else if (bus.rt_data == 32'd0) begin
              // Divide by zero bypasses iteration; result is staged in acc.
              dz_q  <= 1'b1;
              acc   <= {bus.rs_data, 32'hFFFF_FFFF};
              state <= FIX;
            end else begin
              dz_q  <= 1'b0;
              state <= DIV;
            end
`else
            else begin
              state <= FIX;
            end
`endif
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[31:1]};
          cnt <= cnt + 5'd1;
          if (cnt == MDU_CNT_LAST) state <= FIX;
        end
        DIV: begin
          cnt <= cnt + 5'd1;
          if (cnt == MDU_CNT_LAST) state <= FIX;
        end
        FIX: begin
          if (!op_div_q) begin
            {hi_q, lo_q} <= prod_fix;
          end
`ifdef MDU_DIV_EN
          else if (dz_q) begin
            {hi_q, lo_q} <= acc;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          div_zero_q <= op_div_q & dz_q;
`endif
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed vector bench for mult_div_unit
module tb_mult_div_unit;
  import mips_pkg::*;

  logic clk;
  logic rst;
  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    logic        dz;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered just after an edge; start is accepted on the next edge (edge 0).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic dz_seen, output logic busy_at0,
                        output logic busy_at_done, output logic done_after);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = a;
    bus.rt_data = b;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.rs_data = $urandom;
    bus.rt_data = $urandom;
    busy_at0 = bus.busy;
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    dz_seen      = bus.div_zero;
    busy_at_done = bus.busy;
    @(posedge clk); #1;
    done_after = bus.done;
  endtask

  initial begin
    int          lat;
    logic        dz_seen, busy_at0, busy_at_done, done_after;
    logic [31:0] m_hi, m_lo, e_hi, e_lo;
    int          e_lat;
    logic        e_dz;

    vecs[0] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0};
    vecs[1] = '{MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b0};
    vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0};
    vecs[3] = '{MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33, 1'b0};
    vecs[4] = '{MDU_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 33, 1'b0};
    vecs[5] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1'b0};
    vecs[6] = '{MDU_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 33, 1'b0};
    vecs[7] = '{MDU_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1,  1'b1};
    vecs[8] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33, 1'b0};
    vecs[9] = '{MDU_DIV,   32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, 1,  1'b1};

    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.op         = 2'b00;
    bus.rs_data    = '0;
    bus.rt_data    = '0;
    bus.hilo_we    = 1'b0;
    bus.hilo_sel   = 1'b0;
    bus.hilo_wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset hi", bus.hi, 0);
    check("reset lo", bus.lo, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset div_zero", bus.div_zero, 0);
    rst = 1'b1;

    m_hi = '0;
    m_lo = '0;
    for (int i = 0; i < NV; i++) begin
      e_hi = vecs[i].hi; e_lo = vecs[i].lo; e_lat = vecs[i].lat; e_dz = vecs[i].dz;
`ifndef MDU_DIV_EN
      if (vecs[i].op[1]) begin
        e_hi = m_hi; e_lo = m_lo; e_lat = 1; e_dz = 1'b0;
      end
`endif
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, dz_seen, busy_at0, busy_at_done, done_after);
      check($sformatf("v%0d latency", i), lat, e_lat);
      check($sformatf("v%0d hi", i), bus.hi, e_hi);
      check($sformatf("v%0d lo", i), bus.lo, e_lo);
      check($sformatf("v%0d div_zero", i), dz_seen, e_dz);
      check($sformatf("v%0d busy at accept", i), busy_at0, 1);
      check($sformatf("v%0d busy at done", i), busy_at_done, 0);
      check($sformatf("v%0d done width", i), done_after, 0);
      m_hi = e_hi;
      m_lo = e_lo;
    end

    // start and MTHI during a running MULT are both ignored.
    bus.start = 1'b1; bus.op = MDU_MULT; bus.rs_data = 32'd6; bus.rt_data = 32'hFFFF_FFF9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    repeat (9) begin @(posedge clk); #1; lat++; end
    bus.start = 1'b1; bus.op = MDU_MULTU; bus.rs_data = 32'd2; bus.rt_data = 32'd3;
    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b1; bus.hilo_wdata = 32'hDEAD;
    @(posedge clk); #1; lat++;
    bus.start = 1'b0; bus.hilo_we = 1'b0;
    check("busy mid mult", bus.busy, 1);
    check("hi not written while busy", bus.hi, m_hi);
    while (!bus.done && lat < 100) begin @(posedge clk); #1; lat++; end
    check("ignored start latency", lat, 33);
    check("ignored start hi", bus.hi, 32'hFFFF_FFFF);
    check("ignored start lo", bus.lo, 32'hFFFF_FFD6);
    @(posedge clk); #1;
    check("no queued op", bus.busy, 0);

    run_op(MDU_MULTU, 32'd2, 32'd3, lat, dz_seen, busy_at0, busy_at_done, done_after);
    check("resubmit latency", lat, 33);
    check("resubmit lo", bus.lo, 6);
    check("resubmit hi", bus.hi, 0);

    // MTHI / MTLO while idle.
    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b1; bus.hilo_wdata = 32'h1234;
    @(posedge clk); #1;
    bus.hilo_we = 1'b0;
    check("mthi hi", bus.hi, 32'h1234);
    check("mthi lo kept", bus.lo, 6);
    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b0; bus.hilo_wdata = 32'h5678;
    @(posedge clk); #1;
    bus.hilo_we = 1'b0;
    check("mtlo lo", bus.lo, 32'h5678);
    check("mtlo hi kept", bus.hi, 32'h1234);

    // Reset in the middle of an operation.
    bus.start = 1'b1;
`ifdef MDU_DIV_EN
    bus.op = MDU_DIVU; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
`else
    bus.op = MDU_MULTU; bus.rs_data = 32'd9; bus.rt_data = 32'd9;
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("busy before abort", bus.busy, 1);
    rst = 1'b0;
    #1;
    check("abort hi", bus.hi, 0);
    check("abort lo", bus.lo, 0);
    check("abort busy", bus.busy, 0);
    check("abort done", bus.done, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_op(MDU_MULTU, 32'd4, 32'd5, lat, dz_seen, busy_at0, busy_at_done, done_after);
    check("post-reset latency", lat, 33);
    check("post-reset lo", bus.lo, 20);
    check("post-reset hi", bus.hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the Mini-MIPS datapath, sitting directly downstream of the register file. It consumes the `rs_data`/`rt_data` operand pair and executes MULT, MULTU, DIV and DIVU into the architectural HI/LO registers. MTHI and MTLO also write HI/LO through this block. The decode/stall logic holds the pipeline while `busy` is high; MFHI/MFLO read `hi`/`lo` directly.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- start  in  1  launch request; accepted only on an edge where `busy`=0.
- op  in  2  operation select, sampled at accept: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  in  32  operand A (multiplicand / dividend), from the register file.
- rt_data  in  32  operand B (multiplier / divisor), from the register file.
- hilo_we  in  1  MTHI/MTLO write strobe.
- hilo_sel  in  1  write target: 1 = HI, 0 = LO.
- hilo_wdata  in  32  MTHI/MTLO data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO were updated by an operation on the previous edge.
- div_zero  out  1  one-cycle pulse, coincident with `done`, for a divide with `rt_data`=0.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- Accept: on any edge in IDLE with `start`=1.
  - Operand magnitudes, the sign flags (signed ops only) and `op` are latched.
  - A 5-bit iteration counter is cleared.
  - The FSM moves to MUL or DIV.
- MUL: shift-add, one multiplier bit per edge, 32 edges, 64-bit accumulator; then FIX.
- DIV: restoring division, one quotient bit per edge, 32 edges; then FIX.
- FIX: writes HI/LO, pulses `done`, returns to IDLE.
  - MULT: the product is two's-complement negated (64-bit) when the operand signs differ.
  - DIV: the quotient is negated when the signs differ; the remainder takes the dividend's sign.
  - Products: HI = bits 63:32, LO = bits 31:0.
  - Divides: LO = quotient, HI = remainder.
- Unsigned ops skip all sign handling.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (wraps naturally; not flagged).
- Divide by zero (DIV or DIVU with `rt_data`=0), detected at accept:
  - no iterations run;
  - HI = `rs_data`, LO = 0xFFFFFFFF, written on the next edge;
  - `done` and `div_zero` pulse together.
- `start` while `busy`=1 is ignored; it is not queued.
- `hilo_we` while `busy`=1 is ignored.
- `hilo_we` together with an accepted `start` in IDLE: the MTHI/MTLO write is performed and the operation launches. The operation's result later overwrites HI/LO.
- Operands `rs_data`/`rt_data` may change freely after the accept edge.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, FSM in IDLE, counter 0.
- Reset mid-operation aborts the operation immediately. No partial result is written. The block is ready for a new `start` on the first edge after `rst` deasserts.
- MUL/DIV latency: accept at edge 0, iterations on edges 1–32, FIX writes HI/LO on edge 33.
  - `busy` is high from edge 0 until edge 33.
  - `done` is high for the cycle following edge 33.
  - A new `start` is accepted at the earliest on edge 34.
- Divide-by-zero latency: HI/LO written at edge 1; `busy` high for exactly one cycle.
- MTHI/MTLO: the write is visible on `hi`/`lo` one edge after `hilo_we`.
- `hi`/`lo` are registered outputs; they never show intermediate accumulator values.

## Configuration
- `MDU_DIV_EN` defined: the divide path is built and DIV/DIVU behave as specified above.
- `MDU_DIV_EN` undefined: no divider logic is built.
  - DIV/DIVU complete as a no-op: `busy` is high for one cycle and `done` pulses.
  - HI/LO are unchanged.
  - `div_zero` is tied to 0.

## Structure
- Shared package `mips_pkg` holds:
  - the `op` encoding constants (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU);
  - the FSM state typedef;
  - the iteration-count constant (32).
- Sub-module `mdu_divider` holds the restoring-divider datapath (partial remainder, quotient shift register). It is instantiated only under `MDU_DIV_EN`.
- The multiplier datapath and the FSM stay in `mult_div_unit`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 at edge 33; `done` high for exactly one cycle; `busy` low afterwards.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5 / 0 → at edge 1 HI=5, LO=0xFFFFFFFF, with `div_zero` and `done` pulsed together.
- `start` with MULTU 2×3 asserted at cycle 10 of a running MULT → ignored; the first result is correct, then the resubmitted 2×3 → LO=6.
- MTHI 0x1234 while idle → `hi`=0x1234 next edge; `hilo_we` during `busy` → no effect.
- `rst` driven low at cycle 15 of a DIVU → all outputs 0 immediately; after release, MULTU 4×5 → LO=20, HI=0.
